// File: rtl/stereo_stream_pkg.sv
// rtl/stereo_stream_pkg.sv - shared geometry constants, FSM state and pattern encodings
package stereo_stream_pkg;

    localparam int HALF_WIDTH   = 640;
    localparam int LINE_PIXELS  = 1280;
    localparam int ACTIVE_LINES = 480;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VBLANK = 2'd1,
        ST_HBLANK = 2'd2,
        ST_ACTIVE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        PAT_RAMP = 2'b00,
        PAT_BARS = 2'b01,
        PAT_EXT  = 2'b10,
        PAT_GREY = 2'b11
    } pattern_t;

endpackage

// File: rtl/stereo_pattern_gen.sv
// rtl/stereo_pattern_gen.sv - pixel value for a given line position and pattern mode
module stereo_pattern_gen
    import stereo_stream_pkg::*;
#(
    parameter int DISPARITY = 8
) (
    input  logic [10:0] pix_cnt,  // position in the 1280-pixel line (left half, then right)
    input  pattern_t    mode,     // frame pattern, held for the whole frame
    input  logic [7:0]  pix_in,   // external pixel, passed through in PAT_EXT
    output logic [7:0]  pixel     // value to present when this position goes out
);

    logic       half;
    logic [9:0] x;
    logic [10:0] shifted;
    logic [9:0] c;
    logic       unused_c_bits;

    always_comb begin
        half    = (pix_cnt >= 11'(HALF_WIDTH));
        x       = half ? 10'(pix_cnt - 11'(HALF_WIDTH)) : pix_cnt[9:0];
        // DISPARITY is at most 63, so a single conditional subtract implements mod 640.
        shifted = {1'b0, x} + 11'(DISPARITY);
        if (half) begin
            c = (shifted >= 11'(HALF_WIDTH)) ? 10'(shifted - 11'(HALF_WIDTH)) : shifted[9:0];
        end else begin
            c = x;
        end
        unused_c_bits = ^{c[9:5], c[3:0]};

        pixel = 8'h00;
        case (mode)
            PAT_RAMP: pixel = x[7:0];
            PAT_BARS: pixel = c[4] ? 8'hE0 : 8'h20;
            PAT_EXT:  pixel = pix_in;
            PAT_GREY: pixel = 8'h80;
        endcase
    end

endmodule

// File: rtl/stereo_stream_tx.sv
// rtl/stereo_stream_tx.sv - stereo frame/line timing generator with registered video outputs
module stereo_stream_tx
    import stereo_stream_pkg::*;
#(
    parameter int H_BLANK     = 16,
    parameter int V_BLANK     = 64,
    parameter int DISPARITY   = 8,
    parameter int FRAME_LINES = ACTIVE_LINES
) (
    input  logic       pixel_clock,  // single rising-edge clock
    input  logic       reset,        // synchronous, active-high
    input  logic       enable,       // stream enable, seen only in IDLE and at end of frame
    input  logic [1:0] pattern_sel,  // 00 ramp, 01 stereo bars, 10 external, 11 flat grey
    input  logic [7:0] pix_in,       // external pixel, captured in the pix_req cycle
    output logic       pix_req,      // external pixel request, one cycle ahead of line_valid
    output logic       frame_valid,  // high across the active frame
    output logic       line_valid,   // high for 1280 cycles per line
    output logic [7:0] pixel_data,   // pixel value, zero outside line_valid
    output logic       frame_done,   // one-cycle pulse on the first frame_valid-low cycle
    output logic [7:0] frame_count   // completed frames, wraps at 255
);

    localparam logic [15:0] V_LAST    = 16'(V_BLANK - 1);
    localparam logic [15:0] H_LAST    = 16'(H_BLANK - 1);
    localparam logic [10:0] PIX_LAST  = 11'(LINE_PIXELS - 1);
    localparam logic [8:0]  LINE_LAST = 9'(FRAME_LINES - 1);

    state_t      state, state_nxt;
    pattern_t    mode, mode_nxt;
    logic [15:0] blank_cnt, blank_cnt_nxt;
    logic [10:0] pix_cnt, pix_cnt_nxt;
    logic [8:0]  line_cnt, line_cnt_nxt;
    logic        end_of_frame;
    logic [7:0]  pixel_nxt;

    // Outputs are registered from the next-state view so they line up with the state register.
    stereo_pattern_gen #(
        .DISPARITY(DISPARITY)
    ) u_pattern_gen (
        .pix_cnt(pix_cnt_nxt),
        .mode   (mode),
        .pix_in (pix_in),
        .pixel  (pixel_nxt)
    );

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            mode        <= PAT_RAMP;
            blank_cnt   <= '0;
            pix_cnt     <= '0;
            line_cnt    <= '0;
            frame_valid <= 1'b0;
            line_valid  <= 1'b0;
            pixel_data  <= 8'h00;
            frame_done  <= 1'b0;
            frame_count <= 8'h00;
        end else begin
            state       <= state_nxt;
            mode        <= mode_nxt;
            blank_cnt   <= blank_cnt_nxt;
            pix_cnt     <= pix_cnt_nxt;
            line_cnt    <= line_cnt_nxt;
            frame_valid <= (state_nxt == ST_HBLANK) || (state_nxt == ST_ACTIVE);
            line_valid  <= (state_nxt == ST_ACTIVE);
            pixel_data  <= (state_nxt == ST_ACTIVE) ? pixel_nxt : 8'h00;
            frame_done  <= end_of_frame;
            if (end_of_frame) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        mode_nxt      = mode;
        blank_cnt_nxt = blank_cnt;
        pix_cnt_nxt   = pix_cnt;
        line_cnt_nxt  = line_cnt;
        end_of_frame  = 1'b0;
        pix_req       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (enable) begin
                    state_nxt     = ST_VBLANK;
                    blank_cnt_nxt = '0;
                end
            end
            ST_VBLANK: begin
                // Resampled every blanking cycle; the value seen on the last one rules the frame.
                mode_nxt = pattern_t'(pattern_sel);
                if (blank_cnt == V_LAST) begin
                    state_nxt     = ST_HBLANK;
                    blank_cnt_nxt = '0;
                    line_cnt_nxt  = '0;
                end else begin
                    blank_cnt_nxt = blank_cnt + 16'd1;
                end
            end
            ST_HBLANK: begin
                if (blank_cnt == H_LAST) begin
                    state_nxt   = ST_ACTIVE;
                    pix_cnt_nxt = '0;
                    pix_req     = (mode == PAT_EXT);
                end else begin
                    blank_cnt_nxt = blank_cnt + 16'd1;
                end
            end
            ST_ACTIVE: begin
                if (pix_cnt == PIX_LAST) begin
                    blank_cnt_nxt = '0;
                    if (line_cnt == LINE_LAST) begin
                        end_of_frame = 1'b1;
                        state_nxt    = enable ? ST_VBLANK : ST_IDLE;
                    end else begin
                        line_cnt_nxt = line_cnt + 9'd1;
                        state_nxt    = ST_HBLANK;
                    end
                end else begin
                    pix_cnt_nxt = pix_cnt + 11'd1;
                    pix_req     = (mode == PAT_EXT);
                end
            end
        endcase
    end

endmodule

// File: tb/tb_stereo_stream_tx.sv
// tb/tb_stereo_stream_tx.sv - self-checking bench for stereo_stream_tx
module tb_stereo_stream_tx;
    import stereo_stream_pkg::*;

    localparam int H_BLANK     = 16;
    localparam int V_BLANK     = 64;
    localparam int DISPARITY   = 8;
    localparam int FRAME_LINES = 4;
    localparam int LINE_PX     = 1280;

    logic       pixel_clock = 1'b0;
    logic       reset       = 1'b1;
    logic       enable      = 1'b0;
    logic [1:0] pattern_sel = 2'b00;
    logic [7:0] pix_in      = 8'h00;
    logic       pix_req;
    logic       frame_valid;
    logic       line_valid;
    logic [7:0] pixel_data;
    logic       frame_done;
    logic [7:0] frame_count;

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_count    = 0;

    int   cap_gap, cap_lines, cap_len_min, cap_len_max, cap_hgap_min, cap_hgap_max;
    int   cap_tail, cap_zero_bad, cap_req_bad, cap_done_in_frame;
    bit   cap_timeout;
    logic cap_done_end, cap_lv_end;
    logic [7:0] cap_count_end;
    logic [7:0] cap_pix[$];
    logic [7:0] cap_in[$];

    always #5 pixel_clock = ~pixel_clock;

    stereo_stream_tx #(
        .H_BLANK    (H_BLANK),
        .V_BLANK    (V_BLANK),
        .DISPARITY  (DISPARITY),
        .FRAME_LINES(FRAME_LINES)
    ) dut (
        .pixel_clock(pixel_clock),
        .reset      (reset),
        .enable     (enable),
        .pattern_sel(pattern_sel),
        .pix_in     (pix_in),
        .pix_req    (pix_req),
        .frame_valid(frame_valid),
        .line_valid (line_valid),
        .pixel_data (pixel_data),
        .frame_done (frame_done),
        .frame_count(frame_count)
    );

    initial begin
        forever begin
            @(posedge pixel_clock);
            #1 pix_in = 8'($urandom);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1);
    end

    function automatic logic [7:0] model_pixel(input int mode, input int p);
        int x;
        int c;
        x = p % 640;
        c = (p >= 640) ? (x + DISPARITY) % 640 : x;
        case (mode)
            0:       return 8'(x % 256);
            1:       return ((c / 16) % 2 == 1) ? 8'hE0 : 8'h20;
            3:       return 8'h80;
            default: return 8'h00;
        endcase
    endfunction

    task automatic capture_frame(input bit ext, input int drop_line);
        int run;
        int low_run;
        int budget;
        logic prev_req;
        logic [7:0] prev_in;
        cap_gap = 0; cap_lines = 0; cap_len_min = 1 << 30; cap_len_max = 0;
        cap_hgap_min = 1 << 30; cap_hgap_max = 0; cap_tail = 0; cap_zero_bad = 0;
        cap_req_bad = 0; cap_done_in_frame = 0; cap_timeout = 1'b0;
        cap_done_end = 1'bx; cap_lv_end = 1'bx; cap_count_end = 8'hxx;
        cap_pix.delete();
        cap_in.delete();
        prev_req = 1'b0;
        prev_in  = 8'h00;
        budget   = 0;
        @(negedge pixel_clock);
        while (frame_valid !== 1'b1 && budget < 4 * V_BLANK + 16) begin
            cap_gap++;
            budget++;
            if (frame_done !== 1'b0) cap_done_in_frame++;
            prev_req = pix_req;
            prev_in  = pix_in;
            @(negedge pixel_clock);
        end
        if (frame_valid !== 1'b1) begin
            cap_timeout = 1'b1;
            return;
        end
        // The mode was latched during blanking; changing the select now must not matter.
        pattern_sel = 2'($urandom_range(0, 3));
        run = 0;
        low_run = 0;
        budget = 0;
        while (frame_valid === 1'b1 && budget < FRAME_LINES * (LINE_PX + H_BLANK + 4) + 16) begin
            if (prev_req !== (ext && (line_valid === 1'b1))) cap_req_bad++;
            if (frame_done !== 1'b0) cap_done_in_frame++;
            if (line_valid === 1'b1) begin
                if (run == 0) begin
                    cap_lines++;
                    if (low_run < cap_hgap_min) cap_hgap_min = low_run;
                    if (low_run > cap_hgap_max) cap_hgap_max = low_run;
                    low_run = 0;
                    if (cap_lines == drop_line) enable = 1'b0;
                end
                run++;
                cap_pix.push_back(pixel_data);
                cap_in.push_back(prev_in);
            end else begin
                if (run != 0) begin
                    if (run < cap_len_min) cap_len_min = run;
                    if (run > cap_len_max) cap_len_max = run;
                    run = 0;
                end
                low_run++;
                if (pixel_data !== 8'h00) cap_zero_bad++;
            end
            prev_req = pix_req;
            prev_in  = pix_in;
            budget++;
            @(negedge pixel_clock);
        end
        if (frame_valid === 1'b1) begin
            cap_timeout = 1'b1;
            return;
        end
        if (run != 0) begin
            if (run < cap_len_min) cap_len_min = run;
            if (run > cap_len_max) cap_len_max = run;
        end
        cap_tail = low_run;
        if (prev_req !== 1'b0) cap_req_bad++;
        cap_done_end  = frame_done;
        cap_lv_end    = line_valid;
        cap_count_end = frame_count;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b1;
        pattern_sel = 2'b00;
        repeat (3) @(negedge pixel_clock);
        tests_run++; if (frame_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_fv got %b expected 0", frame_valid); end
        tests_run++; if (line_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_lv got %b expected 0", line_valid); end
        tests_run++; if (pixel_data !== 8'h00) begin tests_failed++; $display("FAIL reset_pixel got %h expected 00", pixel_data); end
        tests_run++; if (pix_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req got %b expected 0", pix_req); end
        tests_run++; if (frame_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b expected 0", frame_done); end
        tests_run++; if (frame_count !== 8'h00) begin tests_failed++; $display("FAIL reset_count got %0d expected 0", frame_count); end
        reset = 1'b0;
    endtask

    // Expected gap: counted from the cycle after the call; after a frame the frame_done
    // cycle already consumed one of the V_BLANK low cycles.
    task automatic test_frame(input string name, input int mode, input int exp_gap, input int drop_line);
        int errs;
        int first_bad;
        logic [7:0] exp_px;
        logic [7:0] bad_got;
        logic [7:0] bad_exp;
        pattern_sel = 2'(mode);
        capture_frame(mode == 2, drop_line);
        exp_count = (exp_count + 1) % 256;
        tests_run++; if (cap_timeout !== 1'b0) begin tests_failed++; $display("FAIL %s_timeout got %0d expected 0", name, cap_timeout); end
        tests_run++; if (cap_gap != exp_gap) begin tests_failed++; $display("FAIL %s_vgap got %0d expected %0d", name, cap_gap, exp_gap); end
        tests_run++; if (cap_lines != FRAME_LINES) begin tests_failed++; $display("FAIL %s_lines got %0d expected %0d", name, cap_lines, FRAME_LINES); end
        tests_run++; if (cap_len_min != LINE_PX || cap_len_max != LINE_PX) begin tests_failed++; $display("FAIL %s_line_len got %0d..%0d expected %0d", name, cap_len_min, cap_len_max, LINE_PX); end
        tests_run++; if (cap_hgap_min != H_BLANK || cap_hgap_max != H_BLANK) begin tests_failed++; $display("FAIL %s_hgap got %0d..%0d expected %0d", name, cap_hgap_min, cap_hgap_max, H_BLANK); end
        tests_run++; if (cap_tail != 0 || cap_lv_end !== 1'b0) begin tests_failed++; $display("FAIL %s_fv_fall tail %0d lv %b expected 0 0", name, cap_tail, cap_lv_end); end
        tests_run++; if (cap_zero_bad != 0) begin tests_failed++; $display("FAIL %s_blank_pixel got %0d nonzero expected 0", name, cap_zero_bad); end
        tests_run++; if (cap_req_bad != 0) begin tests_failed++; $display("FAIL %s_pix_req got %0d misplaced expected 0", name, cap_req_bad); end
        tests_run++; if (cap_done_in_frame != 0) begin tests_failed++; $display("FAIL %s_done_early got %0d expected 0", name, cap_done_in_frame); end
        tests_run++; if (cap_done_end !== 1'b1) begin tests_failed++; $display("FAIL %s_done_end got %b expected 1", name, cap_done_end); end
        tests_run++; if (cap_count_end !== 8'(exp_count)) begin tests_failed++; $display("FAIL %s_count got %0d expected %0d", name, cap_count_end, exp_count); end
        errs = 0;
        first_bad = -1;
        bad_got = 8'h00;
        bad_exp = 8'h00;
        for (int i = 0; i < cap_pix.size(); i++) begin
            exp_px = (mode == 2) ? cap_in[i] : model_pixel(mode, i % LINE_PX);
            if (cap_pix[i] !== exp_px) begin
                if (first_bad < 0) begin
                    first_bad = i;
                    bad_got = cap_pix[i];
                    bad_exp = exp_px;
                end
                errs++;
            end
        end
        tests_run++; if (errs != 0 || cap_pix.size() == 0) begin tests_failed++; $display("FAIL %s_pixels %0d wrong of %0d, first at %0d got %h expected %h", name, errs, cap_pix.size(), first_bad, bad_got, bad_exp); end
    endtask

    task automatic test_ramp_values();
        logic [7:0] v;
        if (cap_pix.size() < LINE_PX) begin
            tests_run++; tests_failed++; $display("FAIL ramp_values got %0d pixels expected %0d", cap_pix.size(), LINE_PX);
            return;
        end
        v = cap_pix[255];  tests_run++; if (v !== 8'hFF) begin tests_failed++; $display("FAIL ramp_x255 got %h expected ff", v); end
        v = cap_pix[256];  tests_run++; if (v !== 8'h00) begin tests_failed++; $display("FAIL ramp_x256 got %h expected 00", v); end
        v = cap_pix[639];  tests_run++; if (v !== 8'h7F) begin tests_failed++; $display("FAIL ramp_x639 got %h expected 7f", v); end
        v = cap_pix[640];  tests_run++; if (v !== 8'h00) begin tests_failed++; $display("FAIL ramp_right_x0 got %h expected 00", v); end
        v = cap_pix[1279]; tests_run++; if (v !== 8'h7F) begin tests_failed++; $display("FAIL ramp_right_x639 got %h expected 7f", v); end
    endtask

    task automatic test_bars_values();
        logic [7:0] v;
        if (cap_pix.size() < LINE_PX) begin
            tests_run++; tests_failed++; $display("FAIL bars_values got %0d pixels expected %0d", cap_pix.size(), LINE_PX);
            return;
        end
        v = cap_pix[0];          tests_run++; if (v !== 8'h20) begin tests_failed++; $display("FAIL bars_left_x0 got %h expected 20", v); end
        v = cap_pix[15];         tests_run++; if (v !== 8'h20) begin tests_failed++; $display("FAIL bars_left_x15 got %h expected 20", v); end
        v = cap_pix[16];         tests_run++; if (v !== 8'hE0) begin tests_failed++; $display("FAIL bars_left_x16 got %h expected e0", v); end
        v = cap_pix[640 + 8];    tests_run++; if (v !== 8'hE0) begin tests_failed++; $display("FAIL bars_right_x8 got %h expected e0", v); end
        v = cap_pix[640 + 632];  tests_run++; if (v !== 8'h20) begin tests_failed++; $display("FAIL bars_right_x632 got %h expected 20", v); end
    endtask

    task automatic test_enable_drop();
        int fv_high;
        int done_high;
        test_frame("enable_drop", $urandom_range(0, 3), V_BLANK - 1, 2);
        fv_high = 0;
        done_high = 0;
        repeat (3 * V_BLANK) begin
            @(negedge pixel_clock);
            if (frame_valid !== 1'b0) fv_high++;
            if (frame_done !== 1'b0) done_high++;
        end
        tests_run++; if (fv_high != 0) begin tests_failed++; $display("FAIL idle_fv got %0d high cycles expected 0", fv_high); end
        tests_run++; if (done_high != 0) begin tests_failed++; $display("FAIL idle_done got %0d pulses expected 0", done_high); end
        enable = 1'b1;
    endtask

    task automatic test_reset_mid_frame();
        int lines;
        int run;
        int budget;
        logic prev_lv;
        lines = 0;
        run = 0;
        budget = 0;
        prev_lv = 1'b0;
        @(negedge pixel_clock);
        while (budget < 4 * V_BLANK + FRAME_LINES * 1400) begin
            if (line_valid === 1'b1 && prev_lv !== 1'b1) begin
                lines++;
                run = 0;
            end
            if (line_valid === 1'b1) run++;
            prev_lv = line_valid;
            if (lines == 3 && run == 700) break;
            budget++;
            @(negedge pixel_clock);
        end
        tests_run++; if (!(lines == 3 && run == 700)) begin tests_failed++; $display("FAIL midreset_reach got line %0d pix %0d expected 3 700", lines, run); end
        reset = 1'b1;
        @(negedge pixel_clock);
        tests_run++; if (frame_valid !== 1'b0 || line_valid !== 1'b0) begin tests_failed++; $display("FAIL midreset_fv_lv got %b %b expected 0 0", frame_valid, line_valid); end
        tests_run++; if (pixel_data !== 8'h00) begin tests_failed++; $display("FAIL midreset_pixel got %h expected 00", pixel_data); end
        tests_run++; if (frame_count !== 8'h00) begin tests_failed++; $display("FAIL midreset_count got %0d expected 0", frame_count); end
        tests_run++; if (frame_done !== 1'b0) begin tests_failed++; $display("FAIL midreset_done got %b expected 0", frame_done); end
        reset = 1'b0;
        exp_count = 0;
        test_frame("after_reset", $urandom_range(0, 3), V_BLANK, 0);
    endtask

    initial begin
        test_reset();
        test_frame("ramp", 0, V_BLANK, 0);
        test_ramp_values();
        test_frame("bars", 1, V_BLANK - 1, 0);
        test_bars_values();
        test_frame("external", 2, V_BLANK - 1, 0);
        test_frame("grey", 3, V_BLANK - 1, 0);
        test_frame("random", $urandom_range(0, 3), V_BLANK - 1, 0);
        test_enable_drop();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/stereo_stream_tx.md
STEREO_STREAM_TX -- requirements
Module: stereo_stream_tx

Interface
REQ-001 SHALL provide parameter H_BLANK, default 16, line_valid-low cycles before each line (min 2).
REQ-002 SHALL provide parameter V_BLANK, default 64, frame_valid-low cycles between frames (min 3).
REQ-003 SHALL provide parameter DISPARITY, default 8, right-image column shift in stereo-bar mode (0..63).
REQ-004 Ports, clock and reset first:
- pixel_clock  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  stream enable.
- pattern_sel  in  2  00 ramp, 01 stereo bars, 10 external, 11 flat grey.
- pix_in  in  8  external pixel value (mode 10).
- pix_req  out  1  external pixel request (mode 10).
- frame_valid  out  1  high for the whole active frame.
- line_valid  out  1  high for 1280 cycles per line: 640 left, then 640 right.
- pixel_data  out  8  pixel value; 0 when line_valid low.
- frame_done  out  1  one-cycle pulse at end of frame.
- frame_count  out  8  completed-frame counter.

Function
REQ-005 frame_valid, line_valid and pixel_data SHALL be registered outputs.
REQ-006 States SHALL be IDLE, VBLANK, HBLANK, ACTIVE.
REQ-007 IDLE: fv=lv=0; go to VBLANK when enable=1.
REQ-008 VBLANK: fv=0 for exactly V_BLANK cycles, then HBLANK with line_cnt=0; sample pattern_sel here, hold it for the whole frame.
REQ-009 HBLANK: fv=1, lv=0 for exactly H_BLANK cycles, then ACTIVE with pix_cnt=0.
REQ-010 ACTIVE: lv=1 for exactly 1280 cycles, pix_cnt 0..1279 (11 bits).
- At pix_cnt=1279 with line_cnt<479: line_cnt+1, go to HBLANK.
- At line_cnt=479: fv falls on the same edge as lv.
REQ-011 End of frame:
- frame_done=1 for the one cycle in which fv first reads 0.
- frame_count increments on that cycle; 8-bit wrap 255->0.
- Next state is VBLANK if enable=1, else IDLE.
REQ-012 Deassertion of enable mid-frame SHALL NOT truncate the frame; enable is evaluated only in IDLE and at end of frame.
REQ-013 Column x = pix_cnt for pix_cnt<640, else pix_cnt-640. Half h = 0 left, 1 right.
REQ-014 Pixel value per mode:
- Ramp: pixel_data = x[7:0].
- Stereo bars: let c = x for the left half, c = (x+DISPARITY) mod 640 for the right half. pixel_data = 8'hE0 if c[4]=1, else 8'h20.
- Flat grey: pixel_data = 8'h80.
REQ-015 External mode (10): pix_req=1 in the cycle before each lv=1 cycle (1280 per line). pix_in is captured at the end of that cycle and appears on pixel_data with lv=1 in the next cycle (latency 1). pix_req=0 in all other modes.
REQ-016 All generated values SHALL keep only the top 3 bits meaningful-compatible, i.e. no requirement; full 8 bits are driven.
REQ-017 Line timing SHALL satisfy the receiver: fv low at least 3 consecutive cycles before fv rises; lv low at least 2 cycles before each line.

Reset
REQ-018 On the edge where reset=1, the block SHALL enter IDLE.
REQ-019 In the cycle after that edge: fv=lv=0, pixel_data=0, pix_req=0, frame_done=0, frame_count=0, and all counters cleared.
REQ-020 Reset mid-line SHALL abort the frame immediately; no frame_done pulse.
REQ-021 reset SHALL override enable.

Structure
REQ-022 Package stereo_stream_pkg SHALL hold HALF_WIDTH=640, LINE_PIXELS=1280, ACTIVE_LINES=480, the state encoding and the pattern_sel codes.
REQ-023 Pixel-value generation (REQ-013..015) SHALL be the sub-module stereo_pattern_gen, taking pix_cnt and mode and returning the next pixel; the timing FSM and counters stay in stereo_stream_tx.

Verification
REQ-024 Reset, then enable=1, mode 00 -> fv rises after exactly 64 low cycles; first lv after 16 cycles; pixel_data 0,1,..255,0,..127 (x=639 gives 0x7F), then repeats for the right half.
REQ-025 Full frame -> exactly 480 lv pulses of 1280 cycles each; one frame_done pulse; frame_count=1.
REQ-026 Mode 01, DISPARITY=8:
- Left x=0..15 gives 0x20 and x=16 gives 0xE0.
- Right x=8 gives 0xE0 and x=632 gives 0x20 (wrap).
REQ-027 Mode 10 with pix_in = pix_cnt[7:0] -> pix_req leads lv by one cycle; the pixel_data sequence equals the pix_in sequence delayed one cycle.
REQ-028 enable dropped at line 100 -> frame completes to line 479, frame_done pulses, state goes to IDLE, fv stays 0.
REQ-029 reset asserted at line 200, pix_cnt 700 -> next cycle fv=lv=0 and frame_count=0; no frame_done pulse; a fresh frame follows after 64 cycles if enable=1.
